// File: rtl/serial_pkg.sv
// Shared types for the serial two's-complement datapath: the word framer,
// the invert stage and the serial-to-parallel collector.
package serial_pkg;

  // Default word width used by every stage of the serial chain.
  localparam int WORD_WIDTH = 8;

  // Shifter state: idle or streaming a word out LSB-first.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Registered serial output bundle presented to the invert stage.
  typedef struct packed {
    logic sout;
    logic svalid;
    logic sstart;
    logic slast;
  } ser_t;

  localparam ser_t SER_IDLE = '0;

endpackage

// File: rtl/framer_hold_reg.sv
// Single-entry skid register in front of the shifter. Takes a word on the
// valid/ready handshake and releases it when the FSM pops it into the shifter.
module framer_hold_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic rdy_en;
  logic push;

  // ready is held off through reset and opens on the first edge after release;
  // it never looks at in_valid
  assign in_ready = rdy_en && !hold_full;
  assign push     = in_valid && in_ready;

  // capture on push, empty on pop; the two cannot coincide because pop needs
  // a full register and push needs an empty one
  always_ff @(posedge t_clk) begin
    if (!r_n) begin
      rdy_en    <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (pop) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_framer.sv
// Parallel-to-serial framer. Streams each held word LSB-first, one bit per
// clock, with a start strobe on bit 0 and a last flag on bit WIDTH-1. Words
// waiting in the hold register follow with no idle bit in between.
module serial_word_framer
  import serial_pkg::*;
#(
  parameter  int WIDTH = WORD_WIDTH,       // 2..64
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             svalid,
  output logic             sstart,
  output logic             slast,
  output logic             busy
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    idx, idx_nx, idx_inc;
  ser_t             ser, ser_nx;
  logic             pop, load;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;

  framer_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .t_clk     (t_clk),
    .r_n       (r_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop       (pop),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  assign idx_inc = idx + 1'b1;

  // next-state: idx tracks the bit currently on sout; a load puts bit 0 out
  // directly and parks the remaining bits in shreg
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    ser_nx   = SER_IDLE;
    load     = 1'b0;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      S_SHIFT: begin
        if (idx == LAST_IDX) begin
          // last bit is on the wire: chain the next word or go quiet
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_nx = S_IDLE;
            idx_nx   = '0;
          end
        end else begin
          ser_nx.sout   = shreg[0];
          ser_nx.svalid = 1'b1;
          ser_nx.slast  = (idx_inc == LAST_IDX);
          shreg_nx      = shreg >> 1;
          idx_nx        = idx_inc;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (load) begin
      pop           = 1'b1;
      state_nx      = S_SHIFT;
      shreg_nx      = hold_data >> 1;
      idx_nx        = '0;
      ser_nx.sout   = hold_data[0];
      ser_nx.svalid = 1'b1;
      ser_nx.sstart = 1'b1;
      ser_nx.slast  = 1'b0;
    end
  end

  // state, shifter, bit index and registered serial outputs
  always_ff @(posedge t_clk) begin
    if (!r_n) begin
      state <= S_IDLE;
      shreg <= '0;
      idx   <= '0;
      ser   <= SER_IDLE;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      idx   <= idx_nx;
      ser   <= ser_nx;
    end
  end

  assign sout   = ser.sout;
  assign svalid = ser.svalid;
  assign sstart = ser.sstart;
  assign slast  = ser.slast;
  assign busy   = (state == S_SHIFT) || hold_full;

endmodule

// File: tb/tb_serial_word_framer.sv
// Bench for serial_word_framer: reset, table of single words (bits, flags,
// latency, downstream negation), back-to-back streams, mid-word reset and a
// randomized run against a queue-based model of accepted words.
module tb_serial_word_framer;
  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, sout, svalid, sstart, slast, busy;

  serial_word_framer #(.WIDTH(W)) dut (
    .t_clk(t_clk), .r_n(r_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sout(sout), .svalid(svalid), .sstart(sstart),
    .slast(slast), .busy(busy)
  );

  always #5 t_clk = ~t_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge t_clk) cyc <= cyc + 1;

  typedef struct { logic b; logic st; logic la; int c; } smp_t;
  smp_t         sq[$];
  logic [W-1:0] tx_q[$];
  logic [W-1:0] acc_q[$];
  int           acc_c_q[$];

  // serial stream observer
  always @(negedge t_clk) if (svalid === 1'b1) sq.push_back('{sout, sstart, slast, cyc});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge t_clk);
    #1;
  endtask

  task automatic clear_all();
    sq.delete(); tx_q.delete(); acc_q.delete(); acc_c_q.delete();
  endtask

  // offers tx_q in order; rnd inserts random idle cycles
  task automatic drive_q(input bit rnd, output int stalls);
    int  i = 0;
    int  n = 0;
    logic acc;
    stalls = 0;
    while (i < tx_q.size() && n < 4000) begin
      step(); n++;
      in_data  = tx_q[i];
      in_valid = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      if (acc) acc_c_q.push_back(cyc);
      @(posedge t_clk);
      if (acc) begin acc_q.push_back(in_data); i++; end
    end
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    if (i < tx_q.size()) chk("drive_timeout", i, tx_q.size());
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || svalid) && n < 300) begin step(); n++; end
    chk("drain_idle", {busy, svalid}, 2'b00);
    repeat (2) step();
  endtask

  // two's-complement invert stage: pass bits through the first 1, invert after
  function automatic logic [W-1:0] inv_word(input int k);
    logic found = 1'b0;
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) begin
      r[j] = found ? ~sq[k*W+j].b : sq[k*W+j].b;
      if (sq[k*W+j].b) found = 1'b1;
    end
    return r;
  endfunction

  task automatic check_stream(input string nm, input bit contig);
    int nw;
    logic [W-1:0] w, st, la;
    nw = acc_q.size();
    chk({nm, " nbits"}, sq.size(), nw * W);
    if (sq.size() == nw * W) begin
      for (int k = 0; k < nw; k++) begin
        for (int j = 0; j < W; j++) begin
          w[j]  = sq[k*W+j].b;
          st[j] = sq[k*W+j].st;
          la[j] = sq[k*W+j].la;
        end
        chk({nm, " word"}, w, acc_q[k]);
        chk({nm, " sstart"}, st, 1);
        chk({nm, " slast"}, la, 64'(1) << (W - 1));
        chk({nm, " span"}, sq[k*W+W-1].c - sq[k*W].c, W - 1);
      end
      if (contig && sq.size() > 0)
        chk({nm, " gapless"}, sq[sq.size()-1].c - sq[0].c, sq.size() - 1);
    end
  endtask

  typedef struct { logic [W-1:0] d; logic [W-1:0] neg; } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int stalls;
    tbl[0] = '{8'hB4, 8'h4C};
    tbl[1] = '{8'h06, 8'hFA};
    tbl[2] = '{8'h01, 8'hFF};
    tbl[3] = '{8'hFF, 8'h01};
    tbl[4] = '{8'h80, 8'h80};
    tbl[5] = '{8'h00, 8'h00};
    tbl[6] = '{8'h7F, 8'h81};
    tbl[7] = '{8'hAA, 8'h56};

    // reset with in_valid asserted
    r_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(posedge t_clk);
    step();
    chk("reset outs", {sout, svalid, sstart, slast, busy, in_ready}, 6'b0);
    r_n = 1'b1; in_valid = 1'b0;
    step();
    chk("release in_ready", in_ready, 1'b1);
    chk("release busy/svalid", {busy, svalid}, 2'b00);

    // single words from the table
    for (int t = 0; t < 8; t++) begin
      clear_all();
      tx_q.push_back(tbl[t].d);
      drive_q(1'b0, stalls);
      drain();
      check_stream($sformatf("single%0d", t), 1'b1);
      if (sq.size() == W) begin
        chk($sformatf("single%0d latency", t), sq[0].c - acc_c_q[0], 2);
        chk($sformatf("single%0d negate", t), inv_word(0), tbl[t].neg);
      end
    end

    // back-to-back 01 then FF
    clear_all();
    tx_q.push_back(8'h01); tx_q.push_back(8'hFF);
    drive_q(1'b0, stalls);
    drain();
    check_stream("b2b", 1'b1);

    // four words with valid held: stalls while hold is full, no bubbles
    clear_all();
    for (int k = 0; k < 4; k++) tx_q.push_back(W'($urandom));
    drive_q(1'b0, stalls);
    drain();
    chk("hold4 accepted", acc_q.size(), 4);
    chk("hold4 stalled", stalls > 0, 1'b1);
    check_stream("hold4", 1'b1);

    // reset at bit 3 of AA while 55 waits in hold
    clear_all();
    tx_q.push_back(8'hAA); tx_q.push_back(8'h55);
    drive_q(1'b0, stalls);
    begin
      int n = 0;
      while (sq.size() < 4 && n < 50) begin step(); n++; end
    end
    chk("midrst bit3 reached", sq.size(), 4);
    chk("midrst hold full", in_ready, 1'b0);
    r_n = 1'b0;
    step();
    chk("midrst outs", {sout, svalid, sstart, slast, busy, in_ready}, 6'b0);
    r_n = 1'b1;
    step();
    clear_all();
    tx_q.push_back(8'h0F);
    drive_q(1'b0, stalls);
    drain();
    check_stream("post_rst", 1'b1);

    // randomized traffic against the accepted-word queue
    clear_all();
    for (int k = 0; k < 150; k++) tx_q.push_back(W'($urandom));
    drive_q(1'b1, stalls);
    drain();
    chk("rand accepted", acc_q.size(), 150);
    check_stream("rand", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
